// File: rtl/rom_seq_ctrl.sv
// -----------------------------------------------------------------------------
// rom_seq_ctrl
//
// Sweeps a small combinational 8x4 ROM and streams the words it reads to a
// consumer over a valid/ready handshake. A sweep starts at start_addr and reads
// count words. The address wraps from 7 to 0. A count above 8 is clamped to 8,
// and a count of 0 gives an empty sweep that only pulses done. Each word is
// fetched in one cycle and presented in the next, so the peak rate is one word
// every two cycles. The block also keeps a running sum of the fetched words.
//
// Ports
//   clk         single clock, all state changes on the rising edge
//   rst         asynchronous, active-high reset
//   start       begin a sweep (sampled only while idle)
//   start_addr  first ROM address of the sweep
//   count       number of words to read (0 = empty, 9..15 treated as 8)
//   abort       end the sweep in progress at once, with no done pulse
//   ROM_addr    address to the external ROM (the internal address register)
//   ROM_data    ROM read data, valid in the same cycle as ROM_addr
//   out_data    registered word presented to the consumer
//   out_valid   out_data is valid
//   out_ready   consumer accepts out_data when out_valid is also high
//   out_last    marks the final word of the sweep (qualified by out_valid)
//   busy        high in every state except IDLE
//   done        one-cycle pulse when a sweep completes normally
//   sum         running sum of the words fetched in the current or last sweep
// -----------------------------------------------------------------------------
module rom_seq_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] start_addr,
    input  logic [3:0] count,
    input  logic       abort,
    output logic [2:0] ROM_addr,
    input  logic [3:0] ROM_data,
    output logic [3:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       busy,
    output logic       done,
    output logic [6:0] sum
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_OUT   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t     state;
    state_t     next_state;

    logic [2:0] addr_reg;
    // Words still to be delivered in this sweep. It holds 0..8, so 4 bits are needed.
    logic [3:0] remaining;
    logic [3:0] clamped_count;
    logic       handshake;

    // The widest sweep has 8 words and the widest word is 15, so the total
    // is at most 120. A 7-bit accumulator cannot wrap.
    assign clamped_count = (count > 4'd8) ? 4'd8 : count;

    // A word is accepted only while it is presented. out_ready has no effect
    // in any other state.
    assign handshake = (state == S_OUT) && out_valid && out_ready;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples values from before the edge, whatever the order of the blocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: next_state gets a default before the case so that no path leaves it
    // unassigned. This keeps the block purely combinational, with no latch.
    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE: begin
                // abort has no effect here. start is the only way out of IDLE.
                if (start) begin
                    next_state = (clamped_count != 4'd0) ? S_FETCH : S_DONE;
                end
            end
            S_FETCH: begin
                next_state = abort ? S_IDLE : S_OUT;
            end
            S_OUT: begin
                // abort takes priority over a handshake in the same cycle.
                if (abort) begin
                    next_state = S_IDLE;
                end else if (handshake) begin
                    next_state = out_last ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs decoded from state
    // -------------------------------------------------------------------------
    always_comb begin
        busy     = (state != S_IDLE);
        // If abort arrives while we are in DONE, the completion is suppressed.
        // An aborted sweep never reports done.
        done     = (state == S_DONE) && !abort;
        ROM_addr = addr_reg;
    end

    // -------------------------------------------------------------------------
    // Datapath registers: address, word counter, output word and sum
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_reg  <= 3'd0;
            remaining <= 4'd0;
            out_data  <= 4'd0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            sum       <= 7'd0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    // start is sampled only here. A start seen while busy is
                    // dropped rather than queued.
                    if (start) begin
                        addr_reg  <= start_addr;
                        remaining <= clamped_count;
                        sum       <= 7'd0;
                    end
                end
                S_FETCH: begin
                    if (abort) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end else begin
                        // ROM_data already reflects addr_reg this cycle. Capture
                        // it and add it to the sum in the same edge.
                        out_data  <= ROM_data;
                        sum       <= sum + {3'b000, ROM_data};
                        out_valid <= 1'b1;
                        out_last  <= (remaining == 4'd1);
                    end
                end
                S_OUT: begin
                    if (abort) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end else if (handshake) begin
                        // The 3-bit increment wraps from 7 to 0 with no special case.
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        addr_reg  <= addr_reg + 3'd1;
                        remaining <= remaining - 4'd1;
                    end
                end
                S_DONE: begin
                    // Everything holds. sum keeps its final value until the
                    // next accepted start.
                end
                default: begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Embedded invariants
    // -------------------------------------------------------------------------
    // While a word is stalled, the word, its last flag and the ROM address must
    // not move.
    property p_hold_under_backpressure;
        @(posedge clk) disable iff (rst)
        (state == S_OUT && !out_ready && !abort)
            |=> (state == S_OUT && out_valid && $stable(out_data)
                 && $stable(out_last) && $stable(addr_reg));
    endproperty
    a_hold_under_backpressure: assert property (p_hold_under_backpressure);

    // The OUT state always presents a word, and IDLE never does.
    a_out_has_valid: assert property (
        @(posedge clk) disable iff (rst) (state == S_OUT) |-> out_valid);
    a_idle_no_valid: assert property (
        @(posedge clk) disable iff (rst) (state == S_IDLE) |-> !out_valid);

    // The counter and accumulator stay within their designed ranges.
    a_remaining_range: assert property (
        @(posedge clk) disable iff (rst) remaining <= 4'd8);
    a_sum_range: assert property (
        @(posedge clk) disable iff (rst) sum <= 7'd120);

endmodule

// File: tb/tb_rom_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rom_seq_ctrl
//
// Directed bench for rom_seq_ctrl. The ROM is modelled here with the contents
// 0,C,6,7,8,1,D,E. Inputs change on the falling edge and outputs are sampled
// on the falling edge, half a cycle away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_rom_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] start_addr = 3'd0;
    logic [3:0] count = 4'd0;
    logic       abort = 1'b0;
    logic [2:0] rom_addr;
    logic [3:0] rom_data;
    logic [3:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       out_last;
    logic       busy;
    logic       done;
    logic [6:0] sum;

    logic [3:0] rom [8] = '{4'h0, 4'hC, 4'h6, 4'h7, 4'h8, 4'h1, 4'hD, 4'hE};

    int tests_run    = 0;
    int tests_failed = 0;

    // Words captured by collect(), along with the index of the cycle in which
    // each was accepted.
    logic [3:0] got_data [$];
    logic       got_last [$];
    logic [2:0] got_addr [$];
    int         got_idx  [$];
    int         got_done;
    int         got_busy;
    bit         got_timeout;

    assign rom_data = rom[rom_addr];

    always #5 clk = ~clk;

    rom_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .count      (count),
        .abort      (abort),
        .ROM_addr   (rom_addr),
        .ROM_data   (rom_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done),
        .sum        (sum)
    );

    // Present start for exactly one rising edge. When this returns, the edge
    // has been taken and we are 1 ns past it.
    task automatic start_sweep(input logic [2:0] a, input logic [3:0] c);
        @(negedge clk);
        start      = 1'b1;
        start_addr = a;
        count      = c;
        @(posedge clk);
        #1 start   = 1'b0;
    endtask

    // Sample every falling edge until busy drops, or until the cycle budget
    // runs out. Index 0 is the first falling edge after the call.
    task automatic collect();
        got_data.delete();
        got_last.delete();
        got_addr.delete();
        got_idx.delete();
        got_done    = 0;
        got_busy    = 0;
        got_timeout = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) return;
            got_busy++;
            if (done) got_done++;
            if (out_valid && out_ready) begin
                got_data.push_back(out_data);
                got_last.push_back(out_last);
                got_addr.push_back(rom_addr);
                got_idx.push_back(i);
            end
        end
        got_timeout = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        tests_run++; if (rom_addr !== 3'd0) begin tests_failed++; $display("FAIL reset_rom_addr: got %0d want 0", rom_addr); end
        tests_run++; if (out_data !== 4'd0) begin tests_failed++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        tests_run++; if ({out_valid, out_last, busy, done} !== 4'b0000) begin tests_failed++; $display("FAIL reset_flags: got valid/last/busy/done=%b want 0000", {out_valid, out_last, busy, done}); end
        tests_run++; if (sum !== 7'd0) begin tests_failed++; $display("FAIL reset_sum: got %0d want 0", sum); end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_wait_idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_basic();
        logic [3:0] exp_w [3] = '{4'hC, 4'h6, 4'h7};
        out_ready = 1'b1;
        start_sweep(3'd1, 4'd3);
        collect();
        tests_run++; if (got_timeout !== 1'b0) begin tests_failed++; $display("FAIL basic_timeout: sweep did not finish"); end
        tests_run++; if (got_data.size() != 3) begin tests_failed++; $display("FAIL basic_word_count: got %0d want 3", got_data.size()); end
        for (int i = 0; i < 3 && i < got_data.size(); i++) begin
            tests_run++; if (got_data[i] !== exp_w[i]) begin tests_failed++; $display("FAIL basic_word%0d: got %h want %h", i, got_data[i], exp_w[i]); end
            tests_run++; if (got_last[i] !== (i == 2)) begin tests_failed++; $display("FAIL basic_last%0d: got %b want %b", i, got_last[i], (i == 2)); end
            // The first word appears one cycle after the start edge, then one every two cycles.
            tests_run++; if (got_idx[i] != 1 + 2 * i) begin tests_failed++; $display("FAIL basic_timing%0d: got cycle %0d want %0d", i, got_idx[i], 1 + 2 * i); end
        end
        tests_run++; if (got_done != 1) begin tests_failed++; $display("FAIL basic_done: got %0d pulses want 1", got_done); end
        tests_run++; if (got_busy != 7) begin tests_failed++; $display("FAIL basic_busy_cycles: got %0d want 7", got_busy); end
        tests_run++; if (sum !== 7'd25) begin tests_failed++; $display("FAIL basic_sum: got %0d want 25", sum); end
    endtask

    task automatic test_wrap();
        logic [3:0] exp_w [4] = '{4'hD, 4'hE, 4'h0, 4'hC};
        logic [2:0] exp_a [4] = '{3'd6, 3'd7, 3'd0, 3'd1};
        start_sweep(3'd6, 4'd4);
        collect();
        tests_run++; if (got_data.size() != 4 || got_timeout) begin tests_failed++; $display("FAIL wrap_word_count: got %0d want 4 (timeout=%b)", got_data.size(), got_timeout); end
        for (int i = 0; i < 4 && i < got_data.size(); i++) begin
            tests_run++; if (got_data[i] !== exp_w[i]) begin tests_failed++; $display("FAIL wrap_word%0d: got %h want %h", i, got_data[i], exp_w[i]); end
            tests_run++; if (got_addr[i] !== exp_a[i]) begin tests_failed++; $display("FAIL wrap_addr%0d: got %0d want %0d", i, got_addr[i], exp_a[i]); end
        end
        tests_run++; if (got_done != 1) begin tests_failed++; $display("FAIL wrap_done: got %0d pulses want 1", got_done); end
        tests_run++; if (sum !== 7'd39) begin tests_failed++; $display("FAIL wrap_sum: got %0d want 39", sum); end
    endtask

    task automatic test_count_edges();
        int exp_sum;
        // An empty sweep only spends one cycle in DONE.
        start_sweep(3'd3, 4'd0);
        collect();
        tests_run++; if (got_data.size() != 0) begin tests_failed++; $display("FAIL empty_words: got %0d want 0", got_data.size()); end
        tests_run++; if (got_busy != 1) begin tests_failed++; $display("FAIL empty_busy_cycles: got %0d want 1", got_busy); end
        tests_run++; if (got_done != 1) begin tests_failed++; $display("FAIL empty_done: got %0d pulses want 1", got_done); end
        tests_run++; if (sum !== 7'd0) begin tests_failed++; $display("FAIL empty_sum: got %0d want 0", sum); end
        // A count of 12 is clamped to 8. Starting at 5, the sweep covers the whole ROM once.
        start_sweep(3'd5, 4'd12);
        collect();
        tests_run++; if (got_data.size() != 8 || got_timeout) begin tests_failed++; $display("FAIL clamp_words: got %0d want 8 (timeout=%b)", got_data.size(), got_timeout); end
        exp_sum = 0;
        for (int i = 0; i < 8; i++) begin
            exp_sum += rom[(5 + i) % 8];
            if (i < got_data.size()) begin
                tests_run++; if (got_data[i] !== rom[(5 + i) % 8] || got_last[i] !== (i == 7)) begin tests_failed++; $display("FAIL clamp_word%0d: got %h/last=%b want %h/last=%b", i, got_data[i], got_last[i], rom[(5 + i) % 8], (i == 7)); end
            end
        end
        tests_run++; if (sum !== exp_sum[6:0]) begin tests_failed++; $display("FAIL clamp_sum: got %0d want %0d", sum, exp_sum); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        start_sweep(3'd2, 4'd3);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            tests_run++; if ({out_valid, out_last, out_data, rom_addr} !== {1'b1, 1'b0, 4'h6, 3'd2}) begin tests_failed++; $display("FAIL bp_hold%0d: got valid=%b last=%b data=%h addr=%0d want 1 0 6 2", k, out_valid, out_last, out_data, rom_addr); end
        end
        out_ready = 1'b1;
        collect();
        tests_run++; if (got_data.size() != 2 || got_timeout) begin tests_failed++; $display("FAIL bp_word_count: got %0d want 2 (timeout=%b)", got_data.size(), got_timeout); end
        if (got_data.size() == 2) begin
            tests_run++; if ({got_data[0], got_last[0], got_addr[0]} !== {4'h7, 1'b0, 3'd3}) begin tests_failed++; $display("FAIL bp_word1: got %h/%b/%0d want 7/0/3", got_data[0], got_last[0], got_addr[0]); end
            tests_run++; if ({got_data[1], got_last[1]} !== {4'h8, 1'b1}) begin tests_failed++; $display("FAIL bp_word2: got %h/%b want 8/1", got_data[1], got_last[1]); end
        end
        tests_run++; if (got_done != 1) begin tests_failed++; $display("FAIL bp_done: got %0d pulses want 1", got_done); end
        tests_run++; if (sum !== 7'd21) begin tests_failed++; $display("FAIL bp_sum: got %0d want 21", sum); end
    endtask

    task automatic test_abort();
        int stray;
        out_ready = 1'b1;
        start_sweep(3'd0, 4'd4);
        @(negedge clk);                       // FETCH of word 0
        @(negedge clk);                       // word 0 presented. This start must be ignored.
        start = 1'b1; start_addr = 3'd5; count = 4'd2;
        @(negedge clk);                       // FETCH of word 1
        start = 1'b0;
        @(negedge clk);                       // word 1 presented. Abort here, during a handshake.
        tests_run++; if ({out_valid, out_data} !== {1'b1, 4'hC}) begin tests_failed++; $display("FAIL abort_pre_word: got valid=%b data=%h want 1 C", out_valid, out_data); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        tests_run++; if ({busy, out_valid, out_last, done} !== 4'b0000) begin tests_failed++; $display("FAIL abort_idle: got busy/valid/last/done=%b want 0000", {busy, out_valid, out_last, done}); end
        tests_run++; if (sum !== 7'd12) begin tests_failed++; $display("FAIL abort_sum: got %0d want 12", sum); end
        stray = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (busy || done || out_valid) stray++;
        end
        tests_run++; if (stray != 0) begin tests_failed++; $display("FAIL abort_stays_idle: got %0d active cycles want 0", stray); end
        // Abort while idle is a no-op.
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        tests_run++; if ({busy, sum} !== {1'b0, 7'd12}) begin tests_failed++; $display("FAIL abort_in_idle: got busy=%b sum=%0d want 0 12", busy, sum); end
        start_sweep(3'd4, 4'd2);
        collect();
        tests_run++; if (got_data.size() != 2 || got_timeout) begin tests_failed++; $display("FAIL post_abort_count: got %0d want 2 (timeout=%b)", got_data.size(), got_timeout); end
        if (got_data.size() == 2) begin
            tests_run++; if ({got_data[0], got_last[0], got_data[1], got_last[1]} !== {4'h8, 1'b0, 4'h1, 1'b1}) begin tests_failed++; $display("FAIL post_abort_words: got %h/%b %h/%b want 8/0 1/1", got_data[0], got_last[0], got_data[1], got_last[1]); end
        end
        tests_run++; if (got_done != 1 || sum !== 7'd9) begin tests_failed++; $display("FAIL post_abort_done_sum: got done=%0d sum=%0d want 1 9", got_done, sum); end
    endtask

    task automatic test_reset_mid();
        logic [3:0] exp_w [3] = '{4'h0, 4'hC, 4'h6};
        out_ready = 1'b0;
        start_sweep(3'd5, 4'd4);
        @(negedge clk);
        @(negedge clk);
        tests_run++; if ({out_valid, out_data, sum} !== {1'b1, 4'h1, 7'd1}) begin tests_failed++; $display("FAIL rst_mid_pre: got valid=%b data=%h sum=%0d want 1 1 1", out_valid, out_data, sum); end
        // Reset between clock edges must clear the outputs at once.
        #2 rst = 1'b1;
        #1;
        tests_run++; if ({rom_addr, out_data, out_valid, out_last, busy, done, sum} !== 18'd0) begin tests_failed++; $display("FAIL rst_mid_async: got addr=%0d data=%h valid=%b last=%b busy=%b done=%b sum=%0d want all 0", rom_addr, out_data, out_valid, out_last, busy, done, sum); end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++; if ({busy, out_valid, done} !== 3'b000) begin tests_failed++; $display("FAIL rst_mid_quiet: got busy/valid/done=%b want 000", {busy, out_valid, done}); end
        start_sweep(3'd0, 4'd3);
        collect();
        tests_run++; if (got_data.size() != 3 || got_timeout) begin tests_failed++; $display("FAIL rst_mid_count: got %0d want 3 (timeout=%b)", got_data.size(), got_timeout); end
        for (int i = 0; i < 3 && i < got_data.size(); i++) begin
            tests_run++; if (got_data[i] !== exp_w[i]) begin tests_failed++; $display("FAIL rst_mid_word%0d: got %h want %h", i, got_data[i], exp_w[i]); end
        end
        tests_run++; if (sum !== 7'd18) begin tests_failed++; $display("FAIL rst_mid_sum: got %0d want 18", sum); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_count_edges();
        test_backpressure();
        test_abort();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Guard against a hang anywhere in the sequence.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
